// File: rtl/hazard_ctrl_mc_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The pipeline drives the master side and the controller sits on the slave side.
interface hazard_ctrl_mc_if #(
  parameter int REG_AW = 5
);
  logic              pc_src_e;
  logic [1:0]        result_src_e;
  logic              reg_write_m;
  logic              reg_write_w;
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic [REG_AW-1:0] rd_m;
  logic [REG_AW-1:0] rd_w;
  logic              mdu_start_e;
  logic              mdu_done;
  logic              stall_f;
  logic              stall_d;
  logic              stall_e;
  logic              flush_d;
  logic              flush_e;
  logic              flush_m;
  logic [1:0]        forward_a_e;
  logic [1:0]        forward_b_e;

  modport slave (
    input  pc_src_e, result_src_e, reg_write_m, reg_write_w,
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  mdu_start_e, mdu_done,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
    output forward_a_e, forward_b_e
  );

  modport master (
    output pc_src_e, result_src_e, reg_write_m, reg_write_w,
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output mdu_start_e, mdu_done,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
    input  forward_a_e, forward_b_e
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RISC-V pipeline: forwarding, load-use, branch flush, MDU busy stall.
// Define HAZARD_CTRL_PERF_CNT_EN to add saturating stall/flush performance counters.
module hazard_ctrl_mc #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_ctrl_mc_if.slave     hz
`ifdef HAZARD_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
`endif
);

  if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
    $error("hazard_ctrl_mc: LOAD_LAT must be 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl_mc: CNT_W must be at least 1");
  end

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, MDU_BUSY} state_t;

  state_t     state, state_nxt;
  logic [3:0] lcnt, lcnt_nxt;
  logic       lu_hit;
  logic       stall_f_c, stall_d_c, stall_e_c;
  logic       flush_d_c, flush_e_c, flush_m_c;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              wr_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0 && wr_m && rs == rd_m)      sel = 2'b10;
    else if (rs != '0 && wr_w && rs == rd_w) sel = 2'b01;
    return sel;
  endfunction

  assign lu_hit = (hz.result_src_e == 2'b01) && (hz.rd_e != '0) &&
                  ((hz.rs1_d == hz.rd_e) || (hz.rs2_d == hz.rd_e));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      lcnt  <= lcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lcnt_nxt  = lcnt;
    stall_f_c = 1'b0;
    stall_d_c = 1'b0;
    stall_e_c = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    flush_m_c = 1'b0;
    case (state)
      IDLE: begin
        if (hz.mdu_start_e) begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          stall_e_c = 1'b1;
          flush_m_c = 1'b1;
          if (!hz.mdu_done) state_nxt = MDU_BUSY;
        end else if (hz.pc_src_e) begin
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
        end else if (lu_hit) begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          flush_e_c = 1'b1;
          // The hit cycle is the first bubble; LOAD_WAIT covers the rest.
          if (LOAD_LAT > 1) begin
            lcnt_nxt  = LAT_M1;
            state_nxt = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        stall_f_c = 1'b1;
        stall_d_c = 1'b1;
        flush_e_c = 1'b1;
        lcnt_nxt  = lcnt - 4'd1;
        if (lcnt == 4'd1) state_nxt = IDLE;
      end
      MDU_BUSY: begin
        if (hz.mdu_done) begin
          state_nxt = IDLE;
        end else begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          stall_e_c = 1'b1;
          flush_m_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced quiet for the whole time reset is held, not just at the edge.
  assign hz.stall_f     = rst_n & stall_f_c;
  assign hz.stall_d     = rst_n & stall_d_c;
  assign hz.stall_e     = rst_n & stall_e_c;
  assign hz.flush_d     = rst_n & flush_d_c;
  assign hz.flush_e     = rst_n & flush_e_c;
  assign hz.flush_m     = rst_n & flush_m_c;
  assign hz.forward_a_e = rst_n ? fwd_sel(hz.rs1_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w) : 2'b00;
  assign hz.forward_b_e = rst_n ? fwd_sel(hz.rs2_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w) : 2'b00;

`ifdef HAZARD_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (hz.flush_d && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Parametrised next-generation hazard controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Provides E-stage operand forwarding, load-use stall with configurable load latency, and branch/jump flush.
- Adds a multi-cycle execute-unit (MUL/DIV) busy stall.
- Stall/flush sequencing is a registered FSM with counter; forwarding select is combinational.

Parameters:
REG_AW, 5, register-address width (rs*/rd* ports).
LOAD_LAT, 1, bubble cycles inserted on load-use hazard (1..15).
CNT_W, 16, width of performance counters (optional feature only).

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_src_e  input  1  taken branch/jump resolved in E
result_src_e  input  2  result select of instruction in E; 2'b01 = load
reg_write_m  input  1  M-stage instruction writes rd_m
reg_write_w  input  1  W-stage instruction writes rd_w
rs1_d, rs2_d  input  REG_AW  D-stage source registers
rs1_e, rs2_e, rd_e  input  REG_AW  E-stage source/destination registers
rd_m, rd_w  input  REG_AW  M/W-stage destination registers
mdu_start_e  input  1  multi-cycle op occupies E this cycle (one-cycle pulse)
mdu_done  input  1  multi-cycle result valid (one-cycle pulse)
stall_f, stall_d, stall_e  output  1  hold F/D/E pipeline registers
flush_d, flush_e, flush_m  output  1  bubble into D/E/M registers
forward_a_e, forward_b_e  output  2  operand select: 00 regfile, 01 W result, 10 M ALU result

Behaviour:
- Clock/reset: one clock, clk; reset asynchronous, active-low, rst_n.
- While rst_n=0:
  - state=IDLE, counter=0.
  - All stall/flush outputs 0.
  - forward_* forced to 00.
- Forwarding (combinational, all states):
  - A: 10 if rs1_e==rd_m && reg_write_m && rs1_e!=0.
  - Else 01 if rs1_e==rd_w && reg_write_w && rs1_e!=0.
  - Else 00.
  - B identical using rs2_e.
  - M has priority over W when both match.
- lu_hit (combinational): result_src_e==2'b01 && rd_e!=0 && (rs1_d==rd_e || rs2_d==rd_e).
- FSM states: IDLE, LOAD_WAIT, MDU_BUSY. 4-bit counter lcnt.
- IDLE outputs/transitions, priority order:
  1. mdu_start_e: stall_f=stall_d=stall_e=1, flush_m=1. Next MDU_BUSY, or stays IDLE if mdu_done is also 1 the same cycle (single-cycle completion; outputs as listed). pc_src_e is ignored when mdu_start_e=1.
  2. pc_src_e: flush_d=flush_e=1, stalls 0; overrides lu_hit. Stay IDLE.
  3. lu_hit: stall_f=stall_d=flush_e=1. If LOAD_LAT>1: lcnt<=LOAD_LAT-1, next LOAD_WAIT; else stay IDLE.
  4. Otherwise all 0.
- LOAD_WAIT:
  - Outputs: stall_f=stall_d=flush_e=1; lu_hit and pc_src_e ignored (E holds a bubble).
  - Each cycle lcnt decrements.
  - When lcnt==1 (last bubble cycle), next IDLE.
  - Total bubbles = LOAD_LAT exactly.
- MDU_BUSY:
  - While mdu_done=0: stall_f=stall_d=stall_e=1, flush_m=1.
  - The cycle mdu_done=1: all outputs 0, next IDLE; the pipeline advances that edge.
  - No timeout.
  - mdu_start_e in MDU_BUSY is ignored.
- No output ever has stall_x and flush_x both 1 for the same stage.
- Reset asserted mid-LOAD_WAIT/MDU_BUSY: immediate return to IDLE; lcnt cleared.
- Forwarding is unaffected by the FSM; the datapath qualifies it with stall_e.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0]:
  - stall_cnt increments each cycle stall_f=1.
  - flush_cnt increments each cycle flush_d=1.
  - Both saturate at all-ones (no wrap) and clear on rst_n=0.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Forward priority: rs1_e=5, rd_m=5, rd_w=5, both reg_write=1 -> forward_a_e=10. Set rd_m=0 -> 01. Set rs1_e=0 -> 00.
- Load-use, LOAD_LAT=1: result_src_e=01, rd_e=7, rs2_d=7 -> one cycle stall_f=stall_d=flush_e=1, then all 0. Same with rd_e=0 -> no stall.
- Load-use, LOAD_LAT=3: same hit -> exactly 3 consecutive cycles of stall_f=stall_d=flush_e=1, then IDLE. pc_src_e=1 in cycle 2 -> no flush_d.
- Branch vs load-use: pc_src_e=1 and lu_hit=1 together -> flush_d=flush_e=1, stall_f=stall_d=0.
- MDU: mdu_start_e pulse, mdu_done 4 cycles later -> stall_f/d/e and flush_m high 4 cycles, low on the done cycle. rst_n low in cycle 2 -> all outputs 0 immediately, IDLE after release.
- Perf (macro on, CNT_W=4): 20 stall cycles -> stall_cnt=15 held.
